if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
Fetch stage of the 5-stage MIPS pipeline. It is the producer end of the IF→ID interface and the consumer of the decode stage's branch bus.
- Owns the PC register.
- Computes the next PC from sequential flow or from a branch/jump redirect.
- Drives the synchronous instruction SRAM.
- Holds a redirect that arrives while IF is stalled, so the redirect is not lost.

Parameters:
RESET_PC, 32'hBFBF_FFFC, PC register value during reset; first fetched address is RESET_PC+4 = 32'hBFC0_0000.
STALL_W, 6, width of the stall vector (matches `StallBus).

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
stall  input  STALL_W  pipeline stall vector; bit 0 = IF stall, `Stop=1
br_bus  input  33  {br_e[32], br_addr[31:0]} from decode
if_to_id_bus  output  33  {ce[32], pc[31:0]} to decode
if_adel  output  1  fetch address-error flag, aligned with if_to_id_bus
inst_sram_en  output  1  instruction SRAM enable
inst_sram_wen  output  4  byte write enables, constant 4'b0000
inst_sram_addr  output  32  instruction SRAM address
inst_sram_wdata  output  32  constant 32'h0

Behaviour:
- Reset values: pc_r = RESET_PC, ce_r = 0, redir_v = 0, redir_addr = 0, adel_r = 0.
  - While rst is high: if_to_id_bus = {1'b0, RESET_PC}, if_adel = 0, inst_sram_en = 0.
  - rst asserted mid-operation discards any pending redirect; it takes effect at the next edge.
- next_pc priority:
  1. live br_e=1 → br_addr
  2. else redir_v=1 → redir_addr
  3. else pc_r + 4 (32-bit wrap; 32'hFFFF_FFFC + 4 = 0)
- Delay slot: the instruction already fetched behind a branch proceeds; next_pc is the target. No flush is generated here.
- Advance (stall[0] = NoStop):
  - pc_r <= next_pc, ce_r <= 1, adel_r <= (next_pc[1:0] != 0).
  - redir_v <= 0.
- Hold (stall[0] = Stop):
  - pc_r, ce_r, adel_r hold.
  - If br_e=1: redir_addr <= br_addr, redir_v <= 1. A later br_e while still stalled overwrites.
  - Otherwise redir_v and redir_addr hold.
- SRAM, combinational:
  - inst_sram_addr = next_pc.
  - inst_sram_en = ~rst & ~stall[0] & (next_pc[1:0] == 0).
  - The SRAM returns data one cycle after the request, in the same cycle pc_r shows that address. The fetch-to-data latency is therefore 1 cycle.
- Outputs: if_to_id_bus = {ce_r, pc_r}; if_adel = adel_r.
  - A misaligned PC still advances with ce=1. There is no SRAM access for it. Decode/exception logic consumes if_adel.
- Stall release: no request is issued while stalled. On release, the request for next_pc goes out the same cycle, and pc_r updates at that edge.
- No internal state machine beyond the run/hold condition. The redirect buffer (redir_v, redir_addr) is the only extra state.

Decomposition:
- lib/defines.vh supplies `IF_TO_ID_WD (33), `BR_WD (33), `StallBus, `Stop/`NoStop.
- Add `RESET_PC to defines.vh if a second user appears.
- No sub-module is needed. The next-PC mux and redirect buffer are inline.
- Line budget: 120–160 lines including the redirect buffer and adel logic.

Test Plan:
- Reset held 3 cycles, then released with no stall → addr 32'hBFC0_0000, en=1 in the first cycle. Next cycle if_to_id_bus = {1, 32'hBFC0_0000}, addr 32'hBFC0_0004.
- pc_r = 32'hBFC0_0010, br_bus = {1, 32'hBFC0_0100} for 1 cycle, no stall → addr 32'hBFC0_0100 that cycle. Next cycle pc_r = 32'hBFC0_0100.
- Stall[0]=1 for 2 cycles while br_e pulses 1 cycle with 32'h8000_0040, then release with br_e=0 → en=0 during stall. Release cycle: addr 32'h8000_0040. Afterwards redir_v=0 and addr returns to sequential.
- Stall with pending redirect 32'h8000_0040, and at release live br_e=1 with 32'h8000_0080 → addr 32'h8000_0080. Pending redirect is discarded.
- br_addr = 32'hBFC0_0102 → en=0 that cycle. Next cycle if_adel=1, pc=32'hBFC0_0102. Following fetch at 32'hBFC0_0106 also flags adel.
- rst asserted during stall with redir_v=1 → after reset release the first address is 32'hBFC0_0000, not the stale target.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared widths, stall encoding and helpers for the fetch stage
package if_fetch_unit_pkg;

  localparam int IF_TO_ID_WD = 33;
  localparam int BR_WD       = 33;

  // One stall bit per pipeline stage; a set bit holds that stage
  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  // Word fetches need the low two address bits clear
  function automatic logic addr_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - MIPS IF stage: PC register, next-PC select, redirect buffer, SRAM request
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'hBFBF_FFFC,
  parameter int          STALL_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                   if_adel,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata
);

  logic        br_e;
  logic [31:0] br_addr;
  logic        if_stop;

  logic [31:0] pc_r;
  logic        ce_r;
  logic        adel_r;
  logic        redir_v;
  logic [31:0] redir_addr;
  logic [31:0] next_pc;

  // Only the IF bit of the stall vector matters here
  logic        stall_unused;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign if_stop      = (stall[0] == STOP);
  assign stall_unused = ^stall[STALL_W-1:1];

  // Live branch beats a buffered redirect, which beats sequential flow
  always_comb begin
    next_pc = pc_r + 32'd4;
    if (br_e) begin
      next_pc = br_addr;
    end else if (redir_v) begin
      next_pc = redir_addr;
    end
  end

  // PC advances when IF runs; while held, a branch is parked so it survives the stall
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r       <= RESET_PC;
      ce_r       <= 1'b0;
      adel_r     <= 1'b0;
      redir_v    <= 1'b0;
      redir_addr <= 32'h0;
    end else if (!if_stop) begin
      pc_r    <= next_pc;
      ce_r    <= 1'b1;
      adel_r  <= addr_misaligned(next_pc);
      redir_v <= 1'b0;
    end else if (br_e) begin
      redir_v    <= 1'b1;
      redir_addr <= br_addr;
    end
  end

  // Request goes out one cycle ahead of pc_r; misaligned targets make no access
  assign inst_sram_addr  = next_pc;
  assign inst_sram_en    = ~rst & ~if_stop & ~addr_misaligned(next_pc);
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'h0;

  assign if_to_id_bus = {ce_r, pc_r};
  assign if_adel      = adel_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hBFBF_FFFC;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        if_adel;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_unit #(.RESET_PC(RST_PC), .STALL_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .if_adel         (if_adel),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural PC of the instruction handed to decode, plus a
  // list of branch targets that arrived while fetch was frozen (latest wins).
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_adel;
  logic [31:0] m_pending[$];
  bit          m_valid = 0;

  function automatic logic [31:0] m_target();
    if (br_bus[32]) return br_bus[31:0];
    if (m_pending.size() > 0) return m_pending[m_pending.size()-1];
    return m_pc + 32'd4;
  endfunction

  always @(posedge clk) begin
    logic [31:0] tgt;
    tgt = m_target();
    if (rst) begin
      m_pc = RST_PC; m_ce = 1'b0; m_adel = 1'b0;
      m_pending.delete();
      m_valid = 1;
    end else if (m_valid) begin
      if (!stall[0]) begin
        m_pc = tgt; m_ce = 1'b1; m_adel = (tgt % 4) != 0;
        m_pending.delete();
      end else if (br_bus[32]) begin
        m_pending.push_back(br_bus[31:0]);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [31:0] tgt;
    if (m_valid) begin
      tgt = m_target();
      check("bus",   {31'b0, if_to_id_bus}, {31'b0, m_ce, m_pc});
      check("adel",  {63'b0, if_adel}, {63'b0, m_adel});
      check("addr",  {32'b0, inst_sram_addr}, {32'b0, tgt});
      check("en",    {63'b0, inst_sram_en}, {63'b0, (!rst && !stall[0] && (tgt % 4) == 0)});
      check("wen",   {60'b0, inst_sram_wen}, 64'h0);
      check("wdata", {32'b0, inst_sram_wdata}, 64'h0);
    end
  end

  task automatic drive(input logic r, input logic s, input logic be, input logic [31:0] ba);
    rst = r; stall = {5'b0, s}; br_bus = {be, ba};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 6'b0; br_bus = 33'b0;
    // Reset held for three edges
    for (int i = 0; i < 3; i++) tick();
    drive(1, 0, 0, 32'h0);
    check("rst_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, RST_PC});
    check("rst_en",  {63'b0, inst_sram_en}, 64'h0);
    check("rst_adel", {63'b0, if_adel}, 64'h0);

    // Release: first request at the boot vector
    drive(0, 0, 0, 32'h0);
    check("boot_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0000);
    check("boot_en",   {63'b0, inst_sram_en}, 64'h1);
    tick();
    check("boot_bus",  {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0000});
    check("seq_addr",  {32'b0, inst_sram_addr}, 64'hBFC0_0004);
    for (int i = 0; i < 4; i++) tick();
    check("pc_10", {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0010});

    // Live branch takes effect immediately
    drive(0, 0, 1, 32'hBFC0_0100);
    check("br_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0100);
    tick();
    drive(0, 0, 0, 32'h0);
    check("br_pc", {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0100});

    // Branch during a two-cycle stall is held and used on release
    drive(0, 1, 1, 32'h8000_0040);
    check("stall_en", {63'b0, inst_sram_en}, 64'h0);
    tick();
    drive(0, 1, 0, 32'h0);
    check("stall_en2", {63'b0, inst_sram_en}, 64'h0);
    check("stall_hold", {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0100});
    tick();
    drive(0, 0, 0, 32'h0);
    check("redir_addr", {32'b0, inst_sram_addr}, 64'h8000_0040);
    check("redir_en",   {63'b0, inst_sram_en}, 64'h1);
    tick();
    check("redir_pc",   {31'b0, if_to_id_bus}, {31'b0, 33'h1_8000_0040});
    check("redir_seq",  {32'b0, inst_sram_addr}, 64'h8000_0044);

    // Live branch at release overrides the parked one
    drive(0, 1, 1, 32'h8000_0040);
    tick();
    drive(0, 0, 1, 32'h8000_0080);
    check("ovr_addr", {32'b0, inst_sram_addr}, 64'h8000_0080);
    tick();
    drive(0, 0, 0, 32'h0);
    check("ovr_pc",  {31'b0, if_to_id_bus}, {31'b0, 33'h1_8000_0080});
    check("ovr_seq", {32'b0, inst_sram_addr}, 64'h8000_0084);

    // Misaligned target: no access, adel follows the PC
    drive(0, 0, 1, 32'hBFC0_0102);
    check("mis_en", {63'b0, inst_sram_en}, 64'h0);
    tick();
    drive(0, 0, 0, 32'h0);
    check("mis_adel", {63'b0, if_adel}, 64'h1);
    check("mis_pc",   {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0102});
    check("mis_next", {32'b0, inst_sram_addr}, 64'hBFC0_0106);
    tick();
    check("mis_adel2", {63'b0, if_adel}, 64'h1);
    drive(0, 0, 1, 32'hBFC0_0200);
    tick();
    drive(0, 0, 0, 32'h0);
    check("aligned_adel", {63'b0, if_adel}, 64'h0);

    // Address wraps at the top of the space
    drive(0, 0, 1, 32'hFFFF_FFFC);
    tick();
    drive(0, 0, 0, 32'h0);
    check("wrap_addr", {32'b0, inst_sram_addr}, 64'h0);
    tick();
    check("wrap_pc", {31'b0, if_to_id_bus}, {31'b0, 33'h1_0000_0000});

    // Reset during a stall drops the parked redirect
    drive(0, 1, 1, 32'h8000_0040);
    tick();
    drive(1, 1, 0, 32'h0);
    tick();
    check("rst2_bus", {31'b0, if_to_id_bus}, {31'b0, 1'b0, RST_PC});
    check("rst2_en",  {63'b0, inst_sram_en}, 64'h0);
    drive(0, 0, 0, 32'h0);
    check("rst2_addr", {32'b0, inst_sram_addr}, 64'hBFC0_0000);
    tick();
    check("rst2_pc", {31'b0, if_to_id_bus}, {31'b0, 33'h1_BFC0_0000});
    tick();
    tick();

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
